// File: rtl/sync_fifo_pkg.sv
// Shared defaults for the single-clock FIFO slice.
package sync_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_DEPTH_LOG2 = 7;

endpackage : sync_fifo_pkg

// File: rtl/fifo_ram.sv
// Simple dual-port storage for sync_fifo: one synchronous write port and one
// synchronous read port with registered data. Maps onto block RAM at large depths.
module fifo_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 128,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk_i,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write the addressed word and register the read word on every rising edge.
  // NOTE: the array has no reset so it can map to block RAM; a read of the
  // address written on the same edge returns the old word (the caller bypasses).
  // NOTE: non-blocking assignments keep the read-before-write ordering intact.
  always_ff @(posedge clk_i) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule : fifo_ram

// File: rtl/sync_fifo.sv
// Single-clock FIFO with valid/ready on both sides, full 2**DEPTH_LOG2 capacity,
// occupancy and almost-full/almost-empty status, and a synchronous flush.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int DEPTH_LOG2    = DEFAULT_DEPTH_LOG2,
  parameter int AFULL_THRESH  = (1 << DEPTH_LOG2) - 4,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  flush_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PTR_W = DEPTH_LOG2 + 1;
  localparam logic [PTR_W-1:0] FULL_XOR   = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [31:0]      AFULL_LVL  = AFULL_THRESH;
  localparam logic [31:0]      AEMPTY_LVL = AEMPTY_THRESH;

  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      rd_ptr_inc;
  logic [DEPTH_LOG2-1:0] rd_addr_next;
  logic                  push;
  logic                  pop;
  logic                  wr_en;
  logic                  byp_sel_q;
  logic [DATA_WIDTH-1:0] byp_data_q;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Status is a pure function of the registered pointers, never of the partner handshake.
  assign in_ready_o  = ((wr_ptr ^ rd_ptr) != FULL_XOR);
  assign out_valid_o = (wr_ptr != rd_ptr);
  assign count_o     = wr_ptr - rd_ptr;

  assign push  = in_valid_i & in_ready_o;
  assign pop   = out_valid_o & out_ready_i;
  // A flush discards any word offered in the same cycle.
  assign wr_en = push & ~flush_i;

  assign rd_ptr_inc   = rd_ptr + 1'b1;
  assign rd_addr_next = pop ? rd_ptr_inc[DEPTH_LOG2-1:0] : rd_ptr[DEPTH_LOG2-1:0];

  assign almost_full_o  = (32'(count_o) >= AFULL_LVL);
  assign almost_empty_o = (32'(count_o) <= AEMPTY_LVL);

  // Advance the pointers on each handshake; flush returns both to zero.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr_inc;
    end
  end

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (DEPTH_LOG2)
  ) u_ram (
    .clk_i (clk_i),
    .we    (wr_en),
    .waddr (wr_ptr[DEPTH_LOG2-1:0]),
    .wdata (in_data_i),
    .raddr (rd_addr_next),
    .rdata (ram_rdata)
  );

  // Capture the incoming word when it lands on the next head address, since the
  // RAM would return the stale word; reset selects this register holding zero.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      byp_sel_q  <= 1'b1;
      byp_data_q <= '0;
    end else begin
      byp_sel_q <= wr_en && (wr_ptr[DEPTH_LOG2-1:0] == rd_addr_next);
      if (wr_en) byp_data_q <= in_data_i;
    end
  end

  assign out_data_o = byp_sel_q ? byp_data_q : ram_rdata;

endmodule : sync_fifo

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo (DEPTH=4, AFULL=3, AEMPTY=1): directed cases
// followed by random traffic, checked against a queue-based reference.
module tb_sync_fifo;

  localparam int DW     = 32;
  localparam int DL2    = 2;
  localparam int DEPTH  = 4;
  localparam int AFULL  = 3;
  localparam int AEMPTY = 1;

  logic          clk_i = 1'b0;
  logic          rstn_i = 1'b0;
  logic          flush_i = 1'b0;
  logic [DW-1:0] in_data_i = '0;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [DW-1:0] out_data_o;
  logic          out_valid_o;
  logic          out_ready_i = 1'b0;
  logic [DL2:0]  count_o;
  logic          almost_full_o;
  logic          almost_empty_o;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;
  logic [DW-1:0] exp_q [$];

  sync_fifo #(
    .DATA_WIDTH    (DW),
    .DEPTH_LOG2    (DL2),
    .AFULL_THRESH  (AFULL),
    .AEMPTY_THRESH (AEMPTY)
  ) dut (
    .clk_i          (clk_i),
    .rstn_i         (rstn_i),
    .flush_i        (flush_i),
    .in_data_i      (in_data_i),
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready_o),
    .out_data_o     (out_data_o),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .count_o        (count_o),
    .almost_full_o  (almost_full_o),
    .almost_empty_o (almost_empty_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge and hold until the next one.
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
    @(posedge clk_i);
    #1;
    in_valid_i  = v;
    in_data_i   = d;
    out_ready_i = r;
    flush_i     = f;
  endtask

  // Monitor: on the falling edge compare the DUT against the expected contents,
  // then retire/append entries for the handshakes the coming edge will perform.
  always @(negedge clk_i) begin
    if (mon_en) begin
      int  sz;
      bit  do_pop;
      bit  do_push;
      sz = exp_q.size();
      check("count",        32'(count_o),        32'(sz));
      check("in_ready",     32'(in_ready_o),     32'(sz < DEPTH));
      check("out_valid",    32'(out_valid_o),    32'(sz > 0));
      check("almost_full",  32'(almost_full_o),  32'(sz >= AFULL));
      check("almost_empty", 32'(almost_empty_o), 32'(sz <= AEMPTY));
      if (sz > 0) check("head_data", out_data_o, exp_q[0]);
      if (flush_i) begin
        exp_q.delete();
      end else begin
        do_pop  = out_ready_i && (sz > 0);
        do_push = in_valid_i && (sz < DEPTH);
        if (do_pop)  void'(exp_q.pop_front());
        if (do_push) exp_q.push_back(in_data_i);
      end
    end
  end

  initial begin
    // Reset state, checked while reset is held.
    #1;
    check("rst_in_ready",     32'(in_ready_o),     32'd1);
    check("rst_out_valid",    32'(out_valid_o),    32'd0);
    check("rst_count",        32'(count_o),        32'd0);
    check("rst_out_data",     out_data_o,          32'd0);
    check("rst_almost_empty", 32'(almost_empty_o), 32'd1);
    check("rst_almost_full",  32'(almost_full_o),  32'd0);
    repeat (2) @(posedge clk_i);
    #2;
    rstn_i = 1'b1;
    mon_en = 1'b1;

    // Single word, first-word latency.
    drive(1'b1, 32'hA5A5_0001, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);

    // Fill to full, fifth push ignored, then drain back to back.
    for (int i = 1; i <= 5; i++) drive(1'b1, DW'(i), 1'b0, 1'b0);
    repeat (4) drive(1'b0, 32'h0, 1'b1, 1'b0);
    repeat (2) drive(1'b0, 32'h0, 1'b0, 1'b0);

    // Steady state at count 2 with push and pop every cycle; pointers wrap.
    drive(1'b1, 32'd100, 1'b0, 1'b0);
    drive(1'b1, 32'd101, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) drive(1'b1, DW'(102 + i), 1'b1, 1'b0);
    repeat (3) drive(1'b0, 32'h0, 1'b1, 1'b0);

    // Flush with count 3 and a simultaneous push, then a fresh push.
    for (int i = 0; i < 3; i++) drive(1'b1, DW'(32'h30 + i), 1'b0, 1'b0);
    drive(1'b1, 32'h77, 1'b0, 1'b1);
    drive(1'b1, 32'h55, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    repeat (2) drive(1'b0, 32'h0, 1'b1, 1'b0);

    // Threshold walk 0 -> 4, then drain.
    for (int i = 0; i < 4; i++) drive(1'b1, DW'(32'h40 + i), 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    repeat (4) drive(1'b0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a fill, between clock edges.
    drive(1'b1, 32'h61, 1'b0, 1'b0);
    drive(1'b1, 32'h62, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clk_i);
    #2;
    mon_en = 1'b0;
    rstn_i = 1'b0;
    exp_q.delete();
    #1;
    check("async_rst_count",     32'(count_o),     32'd0);
    check("async_rst_out_valid", 32'(out_valid_o), 32'd0);
    check("async_rst_in_ready",  32'(in_ready_o),  32'd1);
    check("async_rst_out_data",  out_data_o,       32'd0);
    rstn_i = 1'b1;
    mon_en = 1'b1;

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 31) == 0));
    end
    repeat (6) drive(1'b0, 32'h0, 1'b1, 1'b0);
    @(posedge clk_i);
    #1;
    mon_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_sync_fifo
